// File: rtl/cuckoo_table_loader_if.sv
// rtl/cuckoo_table_loader_if.sv - host configuration beat channel for the cuckoo table loader
interface cuckoo_table_loader_if;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_sel;
   logic [10:0] cfg_addr;
   logic [33:0] cfg_data;
   logic        cfg_last;

   modport master (
      output cfg_valid, cfg_sel, cfg_addr, cfg_data, cfg_last,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_sel, cfg_addr, cfg_data, cfg_last,
      output cfg_ready
   );
endinterface

// File: rtl/cuckoo_table_loader.sv
// rtl/cuckoo_table_loader.sv - freezes/drains the cuckoo lookup pipe and writes L1/T3 RAMs from host beats
module cuckoo_table_loader #(
   parameter int PIPE_DEPTH = 4,
   parameter int TIMEOUT    = 64,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   cuckoo_table_loader_if.slave cfg,
   output logic                 pipe_enable,
   output logic                 l1_we,
   output logic                 t3_we,
   output logic                 l1_we_nocase,
   output logic                 t3_we_nocase,
   output logic [10:0]          wr_addr,
   output logic [33:0]          wr_data,
   output logic                 busy,
   output logic                 addr_err,
   output logic                 timeout_err,
   output logic [CNT_W-1:0]     wr_count
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRAIN  = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_RESUME = 2'd3;

   localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam int IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]         state_q, state_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic [IDLE_W-1:0]  idle_q, idle_d;
   logic               pipe_enable_q, pipe_enable_d;
   logic               cfg_ready_q, cfg_ready_d;
   logic               l1_we_q, l1_we_d, t3_we_q, t3_we_d;
   logic               l1_we_nocase_q, l1_we_nocase_d, t3_we_nocase_q, t3_we_nocase_d;
   logic [10:0]        wr_addr_q, wr_addr_d;
   logic [33:0]        wr_data_q, wr_data_d;
   logic               busy_q, busy_d;
   logic               addr_err_q, addr_err_d;
   logic               timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]   wr_count_q, wr_count_d;
   logic               accept;
   logic               bad_t3;

   // cfg_ready is only ever high in WRITE, so this also keeps beats out of other states
   assign accept = (state_q == S_WRITE) && cfg_ready_q && cfg.cfg_valid;
   assign bad_t3 = cfg.cfg_sel[0] && (cfg.cfg_addr[10:9] != 2'b00);

   always_comb begin
      state_d        = state_q;
      drain_d        = drain_q;
      idle_d         = idle_q;
      l1_we_d        = 1'b0;
      t3_we_d        = 1'b0;
      l1_we_nocase_d = 1'b0;
      t3_we_nocase_d = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      addr_err_d     = 1'b0;
      timeout_err_d  = 1'b0;
      wr_count_d     = wr_count_q;
      case (state_q)
         S_IDLE: begin
            if (cfg.cfg_valid) begin
               state_d = S_DRAIN;
               drain_d = DRAIN_W'(PIPE_DEPTH - 1);
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) begin
               state_d = S_WRITE;
               idle_d  = '0;
            end else begin
               drain_d = drain_q - DRAIN_W'(1);
            end
         end
         S_WRITE: begin
            if (accept) begin
               idle_d    = '0;
               wr_addr_d = cfg.cfg_addr;
               wr_data_d = cfg.cfg_sel[0] ? cfg.cfg_data : {25'd0, cfg.cfg_data[8:0]};
               if (bad_t3) begin
                  addr_err_d = 1'b1;
               end else begin
                  case (cfg.cfg_sel)
                     2'd0:    l1_we_d        = 1'b1;
                     2'd1:    t3_we_d        = 1'b1;
                     2'd2:    l1_we_nocase_d = 1'b1;
                     default: t3_we_nocase_d = 1'b1;
                  endcase
                  if (wr_count_q != {CNT_W{1'b1}}) wr_count_d = wr_count_q + CNT_W'(1);
               end
               if (cfg.cfg_last) state_d = S_RESUME;
            end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
               state_d       = S_RESUME;
               timeout_err_d = 1'b1;
               idle_d        = '0;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Outputs are registered against the next state so they line up with it
      pipe_enable_d = (state_d == S_IDLE);
      cfg_ready_d   = (state_d == S_WRITE);
      busy_d        = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         drain_q        <= '0;
         idle_q         <= '0;
         pipe_enable_q  <= 1'b1;
         cfg_ready_q    <= 1'b0;
         l1_we_q        <= 1'b0;
         t3_we_q        <= 1'b0;
         l1_we_nocase_q <= 1'b0;
         t3_we_nocase_q <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         busy_q         <= 1'b0;
         addr_err_q     <= 1'b0;
         timeout_err_q  <= 1'b0;
         wr_count_q     <= '0;
      end else begin
         state_q        <= state_d;
         drain_q        <= drain_d;
         idle_q         <= idle_d;
         pipe_enable_q  <= pipe_enable_d;
         cfg_ready_q    <= cfg_ready_d;
         l1_we_q        <= l1_we_d;
         t3_we_q        <= t3_we_d;
         l1_we_nocase_q <= l1_we_nocase_d;
         t3_we_nocase_q <= t3_we_nocase_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         busy_q         <= busy_d;
         addr_err_q     <= addr_err_d;
         timeout_err_q  <= timeout_err_d;
         wr_count_q     <= wr_count_d;
      end
   end

   assign cfg.cfg_ready  = cfg_ready_q;
   assign pipe_enable    = pipe_enable_q;
   assign l1_we          = l1_we_q;
   assign t3_we          = t3_we_q;
   assign l1_we_nocase   = l1_we_nocase_q;
   assign t3_we_nocase   = t3_we_nocase_q;
   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;
   assign busy           = busy_q;
   assign addr_err       = addr_err_q;
   assign timeout_err    = timeout_err_q;
   assign wr_count       = wr_count_q;
endmodule

// File: tb/tb_cuckoo_table_loader.sv
// tb/tb_cuckoo_table_loader.sv - directed and randomized bench for cuckoo_table_loader with a write scoreboard
module tb_cuckoo_table_loader;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pipe_enable, l1_we, t3_we, l1_we_nocase, t3_we_nocase, busy, addr_err, timeout_err;
   logic [10:0] wr_addr;
   logic [33:0] wr_data;
   logic [CNT_W-1:0] wr_count;

   cuckoo_table_loader_if cfg_if ();

   cuckoo_table_loader #(.PIPE_DEPTH(4), .TIMEOUT(64), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg(cfg_if),
      .pipe_enable(pipe_enable), .l1_we(l1_we), .t3_we(t3_we),
      .l1_we_nocase(l1_we_nocase), .t3_we_nocase(t3_we_nocase),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .addr_err(addr_err), .timeout_err(timeout_err), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   typedef struct { int kind; logic [10:0] addr; logic [33:0] data; int cyc; } ev_t;
   ev_t obs_q[$];
   ev_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int multi_bad = 0;
   int pe_bad = 0;
   int busy_bad = 0;
   int mcount = 0;
   int mwrites = 0;

   logic [1:0]  b_sel [8];
   logic [10:0] b_addr[8];
   logic [33:0] b_data[8];
   logic        b_last[8];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe / addr_err becomes one observed event
   always @(negedge clk) begin
      int n;
      n = int'(l1_we) + int'(t3_we) + int'(l1_we_nocase) + int'(t3_we_nocase);
      if (n > 1) multi_bad = multi_bad + 1;
      if (n > 0 && pipe_enable) pe_bad = pe_bad + 1;
      if (busy !== !pipe_enable) busy_bad = busy_bad + 1;
      if (l1_we)        obs_q.push_back('{0, wr_addr, wr_data, cyc});
      if (t3_we)        obs_q.push_back('{1, wr_addr, wr_data, cyc});
      if (l1_we_nocase) obs_q.push_back('{2, wr_addr, wr_data, cyc});
      if (t3_we_nocase) obs_q.push_back('{3, wr_addr, wr_data, cyc});
      if (addr_err)     obs_q.push_back('{4, 11'd0, 34'd0, cyc});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: T3 with addr[10:9]!=0 is dropped, L1 keeps only 9 data bits, count saturates
   task automatic model_accept(input int i);
      if (b_sel[i][0] && (b_addr[i][10:9] != 2'b00)) begin
         exp_q.push_back('{4, 11'd0, 34'd0, 0});
      end else begin
         if (b_sel[i][0]) exp_q.push_back('{int'(b_sel[i]), b_addr[i], b_data[i], 0});
         else exp_q.push_back('{int'(b_sel[i]), b_addr[i], b_data[i] % 34'd512, 0});
         mwrites++;
         if (mcount < CNT_MAX) mcount++;
      end
   endtask

   task automatic compare_sb(input string tag);
      int n;
      chk({tag, "_events"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
         if (exp_q[i].kind != 4) begin
            chk({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
            chk({tag, "_data"}, obs_q[i].data, exp_q[i].data);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic drive(input int i, input logic v);
      cfg_if.cfg_valid = v;
      cfg_if.cfg_sel   = b_sel[i];
      cfg_if.cfg_addr  = b_addr[i];
      cfg_if.cfg_data  = b_data[i];
      cfg_if.cfg_last  = b_last[i];
   endtask

   task automatic send_beats(input int n, input string tag);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 200) begin
         drive(i, 1'b1);
         if (cfg_if.cfg_ready) begin
            model_accept(i);
            i++;
         end
         @(negedge clk);
         guard++;
      end
      cfg_if.cfg_valid = 1'b0;
      if (i < n) chk({tag, "_beats_accepted"}, i, n);
   endtask

   task automatic rand_beat(input int i, input logic last);
      logic [63:0] r;
      r = {$urandom, $urandom};
      b_sel[i]  = r[1:0];
      b_data[i] = r[35:2];
      b_addr[i] = r[46:36];
      if (b_sel[i][0] && (r[50:48] != 3'd0)) b_addr[i][10:9] = 2'b00;
      b_last[i] = last;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pe"}, pipe_enable, 1'b1);
      chk({tag, "_ready"}, cfg_if.cfg_ready, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_we"}, {l1_we, t3_we, l1_we_nocase, t3_we_nocase}, 4'd0);
      chk({tag, "_addr"}, wr_addr, 11'd0);
      chk({tag, "_data"}, wr_data, 34'd0);
      chk({tag, "_errs"}, {addr_err, timeout_err}, 2'd0);
      chk({tag, "_count"}, wr_count, 0);
   endtask

   initial begin
      logic [6:0] pe_seen, rdy_seen, t3_seen;
      int j;
      int g;
      int nb;
      int bursts;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_sel   = 2'd0;
      cfg_if.cfg_addr  = 11'd0;
      cfg_if.cfg_data  = 34'd0;
      cfg_if.cfg_last  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");

      // Single T3 beat: exact cycle-by-cycle timing
      b_sel[0] = 2'd1; b_addr[0] = 11'h005; b_data[0] = 34'h2DEADBEEF; b_last[0] = 1'b1;
      drive(0, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         pe_seen[k-1]  = pipe_enable;
         rdy_seen[k-1] = cfg_if.cfg_ready;
         t3_seen[k-1]  = t3_we;
         if (k == 5) model_accept(0);
         if (k == 6) begin
            chk("single_addr", wr_addr, 11'h005);
            chk("single_data", wr_data, 34'h2DEADBEEF);
            cfg_if.cfg_valid = 1'b0;
         end
      end
      chk("single_pe_profile", pe_seen, 7'b1000000);
      chk("single_ready_profile", rdy_seen, 7'b0010000);
      chk("single_t3_profile", t3_seen, 7'b0100000);
      chk("single_count", wr_count, mcount);
      compare_sb("single");

      // Four back-to-back L1 beats, junk in the upper data bits
      b_sel[0] = 2'd0; b_addr[0] = 11'h000;
      b_sel[1] = 2'd0; b_addr[1] = 11'h400;
      b_sel[2] = 2'd2; b_addr[2] = 11'h001;
      b_sel[3] = 2'd2; b_addr[3] = 11'h401;
      for (int i = 0; i < 4; i++) begin
         b_data[i] = {$urandom, 2'b11};
         b_last[i] = (i == 3);
      end
      send_beats(4, "burst");
      repeat (3) @(negedge clk);
      if (obs_q.size() >= 4)
         for (int i = 1; i < 4; i++) chk("burst_back_to_back", obs_q[i].cyc - obs_q[0].cyc, i);
      chk("burst_count", wr_count, mcount);
      compare_sb("burst");

      // Out-of-range T3 address dropped, next beat written
      b_sel[0] = 2'd3; b_addr[0] = 11'h200; b_data[0] = 34'h1_2345_6789; b_last[0] = 1'b0;
      b_sel[1] = 2'd1; b_addr[1] = 11'h0AB; b_data[1] = 34'h3_0000_0001; b_last[1] = 1'b1;
      send_beats(2, "t3err");
      repeat (3) @(negedge clk);
      chk("t3err_count", wr_count, mcount);
      compare_sb("t3err");

      // Idle timeout after a non-last beat
      b_sel[0] = 2'd2; b_addr[0] = 11'h07F; b_data[0] = 34'h0_0000_01AA; b_last[0] = 1'b0;
      send_beats(1, "timeout");
      j = 0;
      while (j < 100) begin
         @(negedge clk);
         j++;
         if (j == 63) chk("timeout_ready_last_idle", cfg_if.cfg_ready, 1'b1);
         if (timeout_err) break;
      end
      chk("timeout_cycles", j, 64);
      chk("timeout_resume_pe", pipe_enable, 1'b0);
      chk("timeout_resume_busy", busy, 1'b1);
      chk("timeout_resume_ready", cfg_if.cfg_ready, 1'b0);
      @(negedge clk);
      chk("timeout_idle_pe", pipe_enable, 1'b1);
      chk("timeout_err_pulse", timeout_err, 1'b0);
      compare_sb("timeout");

      // Reset during DRAIN
      b_sel[0] = 2'd1; b_addr[0] = 11'h011; b_data[0] = 34'h1; b_last[0] = 1'b1;
      drive(0, 1'b1);
      repeat (2) @(negedge clk);
      chk("rst_drain_pe_low", pipe_enable, 1'b0);
      rst = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      @(negedge clk);
      mcount = 0;
      chk_reset_outputs("rst_drain");
      rst = 1'b0;
      @(negedge clk);
      chk("rst_drain_pe_after", pipe_enable, 1'b1);

      // Reset with the second beat on the bus one cycle after the first was accepted
      b_sel[0] = 2'd0; b_addr[0] = 11'h123; b_data[0] = 34'h0_0000_0155; b_last[0] = 1'b0;
      b_sel[1] = 2'd2; b_addr[1] = 11'h055; b_data[1] = 34'h0_0000_0077; b_last[1] = 1'b1;
      drive(0, 1'b1);
      g = 0;
      while (!cfg_if.cfg_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("rst_write_reached", cfg_if.cfg_ready, 1'b1);
      model_accept(0);
      @(negedge clk);
      drive(1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      mcount = 0;
      chk_reset_outputs("rst_write");
      rst = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_write_pe_after", pipe_enable, 1'b1);
      compare_sb("rst_write");

      // Random bursts until the counter must have saturated
      mwrites = 0;
      bursts = 0;
      while (mwrites < (1 << CNT_W) + 3 && bursts < 40) begin
         nb = 1 + int'($urandom_range(4, 0));
         for (int i = 0; i < nb; i++) rand_beat(i, i == nb - 1);
         send_beats(nb, "rand");
         repeat (3) @(negedge clk);
         chk("rand_count", wr_count, mcount);
         compare_sb("rand");
         bursts++;
      end
      chk("sat_enough_writes", mwrites >= (1 << CNT_W) + 3, 1'b1);
      chk("sat_count", wr_count, 4'hF);

      chk("strobes_exclusive", multi_bad, 0);
      chk("strobe_while_pipe_on", pe_bad, 0);
      chk("busy_vs_pipe_enable", busy_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
